// File: rtl/cascade_stage_controller.sv
// Per-window Haar cascade controller: walks the stages, accumulates saturated
// weak-classifier sums, compares against each stage threshold, emits a verdict.
module cascade_stage_controller #(
  parameter int NUM_STAGES = 22,
  parameter int SUM_W      = 32,
  parameter int LEN_W      = 8,
  parameter int STG_W      = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             win_valid,
  output logic             win_ready,
  output logic [STG_W-1:0] stage_num,
  input  logic [SUM_W-1:0] stage_thresh,
  input  logic [LEN_W-1:0] stage_len,
  input  logic             wc_valid,
  input  logic [SUM_W-1:0] wc_value,
  output logic             wc_ready,
  output logic             result_valid,
  output logic             result_face,
  output logic [STG_W-1:0] result_stage,
  input  logic             result_ready,
  output logic [2:0]       dbg_state
);

  // Every channel uses valid/ready: a transfer happens on a rising edge where
  // both are high; valid never waits on ready, and ready is a pure state decode.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_ACCUM   = 3'd2,
    S_COMPARE = 3'd3,
    S_DONE    = 3'd4
  } state_e;

  localparam logic [STG_W-1:0] LAST_STG = STG_W'(NUM_STAGES - 1);
  localparam logic [STG_W-1:0] PASS_STG = STG_W'(NUM_STAGES);
  localparam logic [SUM_W-1:0] SAT_MAX  = {1'b0, {(SUM_W-1){1'b1}}};
  localparam logic [SUM_W-1:0] SAT_MIN  = {1'b1, {(SUM_W-1){1'b0}}};

  state_e             state_q,  state_d;
  logic [STG_W-1:0]   stage_q,  stage_d;
  logic [SUM_W-1:0]   thresh_q, thresh_d;
  logic [LEN_W-1:0]   len_q,    len_d;
  logic [LEN_W-1:0]   cnt_q,    cnt_d;
  logic [SUM_W-1:0]   sum_q,    sum_d;
  logic               face_q,   face_d;
  logic [STG_W-1:0]   rstage_q, rstage_d;
  logic [LEN_W:0]     cnt_inc;
  logic               sum_ge;

  // One extra bit catches overflow; clamp when the two top bits disagree.
  function automatic logic [SUM_W-1:0] sat_add(input logic [SUM_W-1:0] a,
                                               input logic [SUM_W-1:0] b);
    logic [SUM_W:0] s;
    s = {a[SUM_W-1], a} + {b[SUM_W-1], b};
    if (s[SUM_W] != s[SUM_W-1]) return s[SUM_W] ? SAT_MIN : SAT_MAX;
    return s[SUM_W-1:0];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      stage_q  <= '0;
      thresh_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      sum_q    <= '0;
      face_q   <= 1'b0;
      rstage_q <= '0;
    end else begin
      state_q  <= state_d;
      stage_q  <= stage_d;
      thresh_q <= thresh_d;
      len_q    <= len_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      face_q   <= face_d;
      rstage_q <= rstage_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    stage_d  = stage_q;
    thresh_d = thresh_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    face_d   = face_q;
    rstage_d = rstage_q;
    cnt_inc  = {1'b0, cnt_q} + (LEN_W+1)'(1);
    sum_ge   = $signed(sum_q) >= $signed(thresh_q);
    unique case (state_q)
      S_IDLE: begin
        if (win_valid && win_ready) begin
          stage_d = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        thresh_d = stage_thresh;
        len_d    = stage_len;
        sum_d    = '0;
        cnt_d    = '0;
        state_d  = (stage_len == '0) ? S_COMPARE : S_ACCUM;
      end
      S_ACCUM: begin
        if (wc_valid) begin
          sum_d = sat_add(sum_q, wc_value);
          cnt_d = cnt_inc[LEN_W-1:0];
          if (cnt_inc == {1'b0, len_q}) state_d = S_COMPARE;
        end
      end
      S_COMPARE: begin
        if (!sum_ge) begin
          face_d   = 1'b0;
          rstage_d = stage_q;
          state_d  = S_DONE;
        end else if (stage_q == LAST_STG) begin
          face_d   = 1'b1;
          rstage_d = PASS_STG;
          state_d  = S_DONE;
        end else begin
          stage_d = stage_q + STG_W'(1);
          state_d = S_LOAD;
        end
      end
      S_DONE: begin
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    win_ready    = (state_q == S_IDLE) && rst_n;
    wc_ready     = (state_q == S_ACCUM);
    result_valid = (state_q == S_DONE);
    result_face  = face_q;
    result_stage = rstage_q;
    stage_num    = stage_q;
    dbg_state    = state_q;
  end

endmodule

// File: tb/tb_cascade_stage_controller.sv
// Bench for cascade_stage_controller: combinational stage lookup, leaf driver,
// arithmetic reference model feeding an expected queue, decoupled result monitor.
module tb_cascade_stage_controller;

  localparam int NS    = 22;
  localparam int SW    = 32;
  localparam int LW    = 8;
  localparam int GW    = 5;
  localparam int MAXL  = 8;
  localparam int EXP_W = 38;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk;
  logic          rst_n;
  logic          win_valid, win_ready;
  logic [GW-1:0] stage_num;
  logic [SW-1:0] stage_thresh;
  logic [LW-1:0] stage_len;
  logic          wc_valid, wc_ready;
  logic [SW-1:0] wc_value;
  logic          result_valid, result_face, result_ready;
  logic [GW-1:0] result_stage;
  logic [2:0]    dbg_state;

  cascade_stage_controller #(.NUM_STAGES(NS), .SUM_W(SW), .LEN_W(LW), .STG_W(GW)) dut (
    .clk(clk), .rst_n(rst_n),
    .win_valid(win_valid), .win_ready(win_ready),
    .stage_num(stage_num), .stage_thresh(stage_thresh), .stage_len(stage_len),
    .wc_valid(wc_valid), .wc_value(wc_value), .wc_ready(wc_ready),
    .result_valid(result_valid), .result_face(result_face),
    .result_stage(result_stage), .result_ready(result_ready),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  int cyc = 0;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- stage tables and combinational lookup ----------------
  logic [SW-1:0] thr_tab [NS];
  logic [LW-1:0] len_tab [NS];
  logic [SW-1:0] leaf_tab[NS][MAXL];

  always_comb begin
    stage_thresh = '0;
    stage_len    = '0;
    for (int i = 0; i < NS; i++) begin
      if (int'(stage_num) == i) begin
        stage_thresh = thr_tab[i];
        stage_len    = len_tab[i];
      end
    end
  end

  // ---------------- scoreboard state ----------------
  logic [EXP_W-1:0] exp_q[$];
  int  checks = 0;
  int  errors = 0;
  bit  win_go = 0, hold_wc = 1, rr_rand = 0;
  int  bp_left = 0;
  int  idx = 0, hs_cnt = 0, wc_rdy_cnt = 0, t0 = 0, rhs_edge = 0;
  bit  wc_pend = 0, win_pend = 0;
  logic [GW-1:0] last_stg = '0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: walk stages with saturating 64-bit arithmetic until a sum falls short.
  // Packed as {latency[15:0], handshakes[15:0], face, stage[4:0]}; latency 0 = unchecked.
  function automatic logic [EXP_W-1:0] model(input bit timed);
    longint s;
    bit face = 1'b1;
    int stg = NS, hs = 0, lat = 1;
    for (int st = 0; st < NS; st++) begin
      s = 0;
      for (int k = 0; k < int'(len_tab[st]); k++) begin
        s = s + longint'($signed(leaf_tab[st][k]));
        if (s > SMAX) s = SMAX;
        if (s < SMIN) s = SMIN;
        hs++;
      end
      lat += 2 + int'(len_tab[st]);
      if (s < longint'($signed(thr_tab[st]))) begin
        face = 1'b0;
        stg  = st;
        break;
      end
    end
    return {timed ? 16'(lat) : 16'd0, 16'(hs), face, 5'(stg)};
  endfunction

  // ---------------- driver ----------------
  initial begin
    win_valid = 0; wc_valid = 0; wc_value = '0; result_ready = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wc_pend = 0; win_pend = 0; idx = 0; wc_valid = 0; win_valid = 0;
        continue;
      end
      if (win_pend) begin
        idx = 0; hs_cnt = 0; wc_rdy_cnt = 0; t0 = cyc; win_go = 0;
      end
      if (wc_pend) begin
        idx++;
        hs_cnt++;
      end
      if (stage_num != last_stg) idx = 0;
      last_stg = stage_num;
      if (wc_ready) wc_rdy_cnt++;
      win_valid = win_go;
      wc_valid  = hold_wc ? 1'b1 : ($urandom_range(0, 3) != 0);
      if (wc_valid && int'(stage_num) < NS && idx < MAXL) wc_value = leaf_tab[int'(stage_num)][idx];
      else wc_value = $urandom;
      if (result_valid && bp_left > 0) begin
        result_ready = 1'b0;
        bp_left--;
      end else begin
        result_ready = rr_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
      win_pend = win_valid && win_ready;
      wc_pend  = wc_valid && wc_ready;
    end
  end

  // ---------------- monitor ----------------
  initial begin
    bit seen = 0, post = 0;
    logic [EXP_W-1:0] e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst_n) begin
        seen = 0; post = 0;
        continue;
      end
      if (post) begin
        chk("win_ready_after_result", longint'(win_ready), 1);
        chk("result_valid_after_result", longint'(result_valid), 0);
        post = 0;
      end
      if (result_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_result face=%0d stage=%0d expected=none", result_face, result_stage);
        end else begin
          e = exp_q[0];
          chk("result_face", longint'(result_face), longint'(e[5]));
          chk("result_stage", longint'(result_stage), longint'(e[4:0]));
          chk("win_ready_in_done", longint'(win_ready), 0);
          if (!seen) begin
            seen = 1;
            if (e[37:22] != 16'd0) chk("latency", longint'(cyc - t0 + 1), longint'(e[37:22]));
          end
          if (result_ready) begin
            chk("wc_handshakes", longint'(hs_cnt), longint'(e[21:6]));
            void'(exp_q.pop_front());
            rhs_edge = cyc + 1;
            seen = 0;
            post = 1;
          end
        end
      end
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic clear_tabs();
    for (int s = 0; s < NS; s++) begin
      thr_tab[s] = '0;
      len_tab[s] = '0;
      for (int k = 0; k < MAXL; k++) leaf_tab[s][k] = '0;
    end
  endtask

  task automatic set_stage(input int s, input int len, input logic [SW-1:0] thr,
                           input logic [SW-1:0] l0, input logic [SW-1:0] l1,
                           input logic [SW-1:0] l2);
    thr_tab[s]     = thr;
    len_tab[s]     = LW'(len);
    leaf_tab[s][0] = l0;
    leaf_tab[s][1] = l1;
    leaf_tab[s][2] = l2;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || win_go) && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (exp_q.size() != 0 || win_go) begin
      checks++; errors++;
      $display("FAIL timeout pending=%0d win_go=%0d expected=0", exp_q.size(), win_go);
      exp_q.delete();
      win_go = 0;
    end
  endtask

  task automatic run_window();
    exp_q.push_back(model(hold_wc));
    win_go = 1;
    wait_drain(3000);
  endtask

  task automatic wait_accept(input int budget);
    int n = 0;
    while (win_go && n < budget) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (win_go) begin
      checks++; errors++;
      $display("FAIL accept_timeout win_go=%0d expected=0", win_go);
      win_go = 0;
    end
  endtask

  task automatic stage0_reject();
    clear_tabs();
    set_stage(0, 3, 32'h0000D29C, 32'h4000, 32'h4000, 32'h5000);
    set_stage(1, 2, 32'h0, 32'h1000, 32'h1000, 32'h0);
  endtask

  // ---------------- main ----------------
  initial begin
    int n;
    rst_n = 1'b0;
    clear_tabs();
    #2;
    chk("rst_win_ready", longint'(win_ready), 0);
    chk("rst_wc_ready", longint'(wc_ready), 0);
    chk("rst_result_valid", longint'(result_valid), 0);
    chk("rst_stage_num", longint'(stage_num), 0);
    chk("rst_result_stage", longint'(result_stage), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("idle_win_ready", longint'(win_ready), 1);

    hold_wc = 1; rr_rand = 0;
    stage0_reject();
    run_window();

    clear_tabs();
    for (int s = 0; s < NS; s++) set_stage(s, 2, 32'h00010000, 32'h8000, 32'h8000, 32'h0);
    run_window();

    clear_tabs();
    for (int s = 0; s < 5; s++) set_stage(s, 1, 32'h0, 32'h00010000, 32'h0, 32'h0);
    set_stage(5, 2, 32'h0, 32'hFFFF8000, 32'hFFFF8000, 32'h0);
    for (int s = 6; s < NS; s++) set_stage(s, 2, 32'h0, 32'h00010000, 32'h00010000, 32'h0);
    run_window();

    clear_tabs();
    set_stage(0, 2, 32'h7FFFFFFF, 32'h7FFF0000, 32'h7FFF0000, 32'h0);
    run_window();
    set_stage(1, 2, 32'h80000001, 32'h80010000, 32'h80010000, 32'h0);
    run_window();
    set_stage(1, 2, 32'h80000000, 32'h80010000, 32'h80010000, 32'h0);
    run_window();

    clear_tabs();
    run_window();
    chk("empty_wc_ready_cycles", longint'(wc_rdy_cnt), 0);

    // Backpressured reject followed by a second window waiting on win_valid.
    set_stage(0, 0, 32'h1, 32'h0, 32'h0, 32'h0);
    bp_left = 5;
    exp_q.push_back(model(1'b1));
    win_go = 1;
    wait_accept(100);
    exp_q.push_back(model(1'b1));
    win_go = 1;
    wait_accept(100);
    chk("back_to_back_accept_edge", longint'(t0), longint'(rhs_edge + 1));
    wait_drain(200);

    // Reset while one leaf of stage 2 has been accepted.
    clear_tabs();
    set_stage(0, 1, 32'h0, 32'h00010000, 32'h0, 32'h0);
    set_stage(1, 1, 32'h0, 32'h00010000, 32'h0, 32'h0);
    set_stage(2, 3, 32'h0, 32'h1000, 32'h1000, 32'h1000);
    exp_q.push_back(model(1'b1));
    win_go = 1;
    n = 0;
    while (!(stage_num == 5'd2 && idx == 1) && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("reached_stage2_leaf1", longint'(int'(stage_num == 5'd2 && idx == 1)), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_win_ready", longint'(win_ready), 0);
    chk("midrst_wc_ready", longint'(wc_ready), 0);
    chk("midrst_result_valid", longint'(result_valid), 0);
    chk("midrst_stage_num", longint'(stage_num), 0);
    chk("midrst_result_face", longint'(result_face), 0);
    chk("midrst_result_stage", longint'(result_stage), 0);
    chk("midrst_state", longint'(dbg_state), 0);
    exp_q.delete();
    win_go = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    stage0_reject();
    run_window();

    // Randomized windows with leaf gaps and result backpressure.
    rr_rand = 1;
    for (int w = 0; w < 40; w++) begin
      int deep;
      hold_wc = ($urandom_range(0, 1) == 1);
      deep = $urandom_range(0, 1);
      clear_tabs();
      for (int s = 0; s < NS; s++) begin
        len_tab[s] = LW'($urandom_range(0, 3));
        thr_tab[s] = SW'(int'($urandom_range(0, 32'h80000)) - (deep != 0 ? 32'h70000 : 32'h30000));
        for (int k = 0; k < MAXL; k++) begin
          case ($urandom_range(0, 7))
            0:       leaf_tab[s][k] = 32'h7FFF0000;
            1:       leaf_tab[s][k] = 32'h80010000;
            default: leaf_tab[s][k] = SW'(int'($urandom_range(0, 32'h40000)) - 32'h20000);
          endcase
        end
      end
      if ($urandom_range(0, 3) == 0) bp_left = $urandom_range(1, 4);
      run_window();
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cascade_stage_controller.md
Name: cascade_stage_controller

Overview:
- Per-window controller of the Haar cascade. Sits directly downstream of the stage-threshold lookup and drives that lookup's stage index.
- For one candidate window it walks stages 0..NUM_STAGES-1. In each stage it accumulates the weak-classifier leaf values, compares the sum with the stage threshold, and either advances to the next stage or rejects the window.
- It emits one face/non-face verdict per window.

Parameters:
- NUM_STAGES, default 22: number of cascade stages.
- SUM_W, default 32: width of the signed Q16.16 fixed-point values (leaf values, sums, thresholds).
- LEN_W, default 8: width of the weak-classifier-per-stage count.
- STG_W, default 5: width of the stage index. Must hold the value NUM_STAGES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- win_valid  in  1  new window is ready to be classified.
- win_ready  out  1  controller is idle and accepts a window.
- stage_num  out  STG_W  current stage index, driven to the threshold/length lookup.
- stage_thresh  in  SUM_W  signed Q16.16 threshold for stage_num. Combinational from stage_num.
- stage_len  in  LEN_W  number of weak classifiers in stage_num. Combinational from stage_num.
- wc_valid  in  1  weak-classifier leaf value is valid.
- wc_value  in  SUM_W  signed Q16.16 leaf value.
- wc_ready  out  1  controller accepts a leaf value.
- result_valid  out  1  verdict is valid.
- result_face  out  1  1 = passed all stages.
- result_stage  out  STG_W  stage that rejected the window, or NUM_STAGES if the window passed.
- result_ready  in  1  consumer takes the verdict.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE; stage_num, sum, count, result_face and result_stage = 0.
  - result_valid = 0, wc_ready = 0.
  - win_ready = (state==IDLE) & rst_n, so it is 0 while reset is held.
  - Reset mid-operation abandons the window. No verdict is produced.
- States: IDLE, LOAD, ACCUM, COMPARE, DONE.
- IDLE:
  - win_ready = 1.
  - A win_valid & win_ready handshake sets stage_num = 0 and moves to LOAD.
- LOAD (1 cycle):
  - Register stage_thresh and stage_len; clear sum and count.
  - If the latched len == 0, go to COMPARE; otherwise go to ACCUM.
- ACCUM:
  - wc_ready = 1.
  - Each wc_valid & wc_ready handshake does sum <= sat(sum + wc_value) and count++.
  - The handshake that makes count == len moves to COMPARE in the next cycle. wc_ready is 0 in COMPARE.
  - wc_valid gaps are allowed; the state holds.
- Saturation: the addition uses SUM_W+1 bits, then clamps to 0x7FFFFFFF / 0x80000000 for SUM_W = 32.
- COMPARE (1 cycle), signed compare:
  - If sum >= thresh and stage_num == NUM_STAGES-1: face = 1, result_stage = NUM_STAGES, go to DONE.
  - If sum >= thresh and not the last stage: stage_num++, go to LOAD.
  - If sum < thresh: face = 0, result_stage = stage_num, go to DONE. The remaining stages are skipped.
- DONE:
  - result_valid = 1, with result_face and result_stage held stable.
  - A result_ready handshake moves to IDLE. The earliest next window is accepted one cycle later.
- wc_valid outside ACCUM is ignored; no handshake occurs.
- Per-stage overhead is 2 cycles (LOAD, COMPARE) plus len accepted leaf values.
- Minimum window latency, from win handshake to result_valid: 3 cycles (stage 0 rejected with len = 0).
- stage_num is stable from LOAD through COMPARE of each stage. The lookup may be purely combinational.

Test Plan:
- Stage-0 reject: stage_len = 3, thresh = 0x0000D29C (0.8227). Leaf values 0x4000, 0x4000, 0x5000 (sum 0xD000) -> one verdict with face = 0, result_stage = 0. stage_num never leaves 0. Exactly 3 wc handshakes.
- Full pass: every stage has len = 2, thresh = 0x00010000, leaf values 0x8000 each (sum equals thresh) -> stage_num steps 0..21, result_face = 1, result_stage = 22. Latency = 1 + 22*(2+2) cycles with wc_valid held high.
- Mid-cascade reject: stages 0-4 pass, stage 5 sum = 0xFFFF0000 (-1.0) with thresh 0 -> face = 0, result_stage = 5, no wc handshakes after stage 5.
- Saturation: len = 2, leaf values 0x7FFF0000 twice -> sum 0x7FFFFFFF. 0x80010000 twice -> sum 0x80000000. Compare against thresh 0x7FFFFFFF gives pass; against 0x80000001 gives reject.
- Empty stage and backpressure: len = 0 with thresh 0 -> pass and wc_ready stays 0; len = 0 with thresh 1 -> reject. Hold result_ready low 5 cycles -> result_valid, face and stage stable and win_ready = 0; a win accept is observed in the cycle after the result handshake.
- Reset mid-ACCUM: assert rst_n low after 1 of 3 leaf values in stage 2 -> all outputs return to their reset values immediately. The next window starts at stage_num = 0 with sum 0; a stage-0 reject gives result_stage = 0.
